// File: rtl/reg_scan.sv
// reg_scan: debug read-out engine for a 2**PW-entry register file.
// On a start pulse it walks every register index, samples each value from the
// combinational read port and streams it out over a valid/ready interface.
// Optional feature macro: SCAN_CHECKSUM_EN appends an XOR checksum byte.
module reg_scan #(
    parameter int PW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [PW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_CSUM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [PW-1:0] LAST_IDX = {PW{1'b1}};

    logic [2:0]    state, state_nxt;
    logic [PW-1:0] idx, idx_nxt;
    logic [DW-1:0] data_q, data_nxt;
`ifdef SCAN_CHECKSUM_EN
    logic [DW-1:0] csum, csum_nxt;
`endif

    // Next-state, index, output byte and checksum update.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        data_nxt  = data_q;
`ifdef SCAN_CHECKSUM_EN
        csum_nxt  = csum;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    idx_nxt   = '0;
`ifdef SCAN_CHECKSUM_EN
                    csum_nxt  = '0;
`endif
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                data_nxt  = rd_data;
`ifdef SCAN_CHECKSUM_EN
                csum_nxt  = csum ^ rd_data;
`endif
                state_nxt = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
`ifdef SCAN_CHECKSUM_EN
                        // csum already holds the final byte folded in at FETCH.
                        data_nxt  = csum;
                        state_nxt = S_CSUM;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_CSUM: begin
`ifdef SCAN_CHECKSUM_EN
                if (out_ready) begin
                    state_nxt = S_DONE;
                end
`else
                // Unreachable without the checksum feature.
                state_nxt = S_IDLE;
`endif
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; an in-flight byte is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            data_q <= '0;
`ifdef SCAN_CHECKSUM_EN
            csum   <= '0;
`endif
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            data_q <= data_nxt;
`ifdef SCAN_CHECKSUM_EN
            csum   <= csum_nxt;
`endif
        end
    end

    // Outputs are registered or decoded from state only.
    always_comb begin
        rd_addr   = idx;
        out_data  = data_q;
        out_valid = (state == S_SEND) || (state == S_CSUM);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
    end

endmodule

// File: tb/tb_reg_scan.sv
// Self-checking bench for reg_scan: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a transaction model.
module tb_reg_scan;

    localparam int NREG = 16;
`ifdef SCAN_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int NB = NREG + (CK ? 1 : 0);

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    logic [7:0] core [NREG];
    assign rd_data = core[rd_addr];

    reg_scan #(.PW(4), .DW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;
    logic [7:0] stream [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Model: position in the byte sequence plus a one-cycle fetch gap per register.
    bit         m_busy, m_gap, m_valid, m_done, m_sumphase;
    logic [7:0] m_data, m_sum;
    logic [3:0] m_addr;
    int         m_pos;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_gap = 0; m_valid = 0; m_done = 0; m_sumphase = 0;
            m_data = 8'h00; m_sum = 8'h00; m_addr = 4'h0; m_pos = 0;
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_gap = 1; m_pos = 0; m_addr = 4'h0; m_sum = 8'h00;
            end
        end else if (m_gap) begin
            m_data  = core[m_pos];
            m_sum   = m_sum ^ m_data;
            m_gap   = 0;
            m_valid = 1;
        end else if (m_valid && out_ready) begin
            if (m_sumphase) begin
                m_sumphase = 0; m_valid = 0; m_done = 1;
            end else if (m_pos == NREG - 1) begin
                if (CK) begin
                    m_sumphase = 1;
                    m_data     = m_sum;
                end else begin
                    m_valid = 0;
                    m_done  = 1;
                end
            end else begin
                m_pos   = m_pos + 1;
                m_addr  = 4'(m_pos);
                m_gap   = 1;
                m_valid = 0;
            end
        end
    end

    // Per-cycle comparison and accepted-byte capture, away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (out_valid !== m_valid || busy !== m_busy || done !== m_done ||
                rd_addr !== m_addr || out_data !== m_data) begin
                $display("FAIL cycle_model @%0d: got v=%b b=%b d=%b a=%h o=%h, expected v=%b b=%b d=%b a=%h o=%h",
                         cyc, out_valid, busy, done, rd_addr, out_data,
                         m_valid, m_busy, m_done, m_addr, m_data);
            end else begin
                n_pass++;
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1 && reset === 1'b0) stream.push_back(out_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int n = 0; n < 300; n++) begin
            step();
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            n_checks++;
            $display("FAIL wait_done: got no done pulse, expected one within 300 cycles");
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            $display("FAIL wait_idle: got busy=%b, expected 0 within 300 cycles", busy);
        end
    endtask

    task automatic preload_ramp();
        for (int i = 0; i < NREG; i++) core[i] = 8'(8'h10 + i);
    endtask

    // Start a scan; returns the cycle number in which start was sampled.
    task automatic kick(output int sc, output int base);
        base  = stream.size();
        start = 1'b1;
        sc    = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic check_ramp(input string name, input int base);
        check({name, "_count"}, stream.size() - base, NB);
        for (int k = 0; k < NREG; k++) begin
            if (base + k < stream.size()) check({name, "_byte"}, int'(stream[base + k]), 8'h10 + k);
        end
    endtask

    initial begin
        int sc, dc, dc2, base;
        logic [7:0] x;
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < NREG; i++) core[i] = 8'h00;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_rd_addr", int'(rd_addr), 0);
        check("reset_out_data", int'(out_data), 0);

        // Basic full scan with sink always ready.
        preload_ramp();
        out_ready = 1'b1;
        kick(sc, base);
        check("fetch_busy", int'(busy), 1);
        wait_done(dc);
        check("done_cycle", dc - sc, CK ? 34 : 33);
        check_ramp("basic", base);
        if (CK && stream.size() > base + 16) check("basic_csum", int'(stream[base + 16]), 8'h00);
        step();
        check("idle_after_done", int'(busy), 0);

        // Three stall cycles while byte 5 is presented.
        kick(sc, base);
        while (cyc - sc < 12) step();
        check("stall_valid", int'(out_valid), 1);
        check("stall_data0", int'(out_data), 8'h15);
        out_ready = 1'b0;
        step();
        check("stall_data1", int'(out_data), 8'h15);
        step();
        check("stall_data2", int'(out_data), 8'h15);
        step();
        out_ready = 1'b1;
        check("stall_data3", int'(out_data), 8'h15);
        wait_done(dc);
        check("stall_done_cycle", dc - sc, CK ? 37 : 36);
        check_ramp("stall", base);
        wait_idle();

        // start held high: back-to-back scans, DONE-cycle start ignored.
        start = 1'b1;
        wait_done(dc);
        wait_done(dc2);
        check("held_start_period", dc2 - dc, CK ? 35 : 34);
        start = 1'b0;
        wait_idle();

        // Reset while byte 7 is in SEND, then rescan from index 0.
        kick(sc, base);
        while (cyc - sc < 16) step();
        check("pre_reset_data", int'(out_data), 8'h17);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset_valid", int'(out_valid), 0);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_addr", int'(rd_addr), 0);
        kick(sc, base);
        wait_done(dc);
        check_ramp("rescan", base);
        wait_idle();

        // Register 3 rewritten after its fetch: stream keeps the old value.
        kick(sc, base);
        while (cyc - sc < 9) step();
        core[3] = 8'hAA;
        wait_done(dc);
        if (stream.size() > base + 3) check("late_write_byte3", int'(stream[base + 3]), 8'h13);
        if (CK && stream.size() > base + 16) begin
            x = 8'h00;
            for (int k = 0; k < NREG; k++) x ^= stream[base + k];
            check("late_write_csum", int'(stream[base + 16]), int'(x));
            check("late_write_csum_lit", int'(stream[base + 16]), 8'h00);
        end
        wait_idle();

        // Checksum corner patterns.
        for (int i = 0; i < NREG; i++) core[i] = 8'hFF;
        kick(sc, base);
        wait_done(dc);
        check("ff_count", stream.size() - base, NB);
        if (CK && stream.size() > base + 16) check("ff_csum", int'(stream[base + 16]), 8'h00);
        wait_idle();
        for (int i = 0; i < NREG; i++) core[i] = 8'h00;
        core[0] = 8'h5A;
        kick(sc, base);
        wait_done(dc);
        if (stream.size() > base) check("5a_byte0", int'(stream[base]), 8'h5A);
        if (CK && stream.size() > base + 16) check("5a_csum", int'(stream[base + 16]), 8'h5A);
        wait_idle();

        // Randomized traffic: ready, start, register writes and rare resets.
        for (int n = 0; n < 4000; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 7) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) core[$urandom_range(0, NREG - 1)] = 8'($urandom);
            step();
        end
        start = 1'b0; reset = 1'b0; out_ready = 1'b1;
        wait_idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
